// File: rtl/ram2_arbiter.sv
// Two-requester arbiter for RAM port 2: fixed priority to requester 0 with a
// starvation override for requester 1, plus read-return routing by owner.
module ram2_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr2,
  output logic [DATA_W-1:0] ram_in2,
  output logic              ram_w_en2,
  input  logic [DATA_W-1:0] ram_data2
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM_C = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0]  starve_cnt_r;
  logic [RD_LAT-1:0] pipe_vld_r;
  logic [RD_LAT-1:0] pipe_own_r;
  logic              sel0_s;
  logic              sel1_s;
  logic              starved_s;
  logic              rd_issue_s;
  logic              tail_vld_s;
  logic              tail_own_s;

  // Winner selection; nothing is granted while reset is asserted.
  always_comb begin
    sel0_s    = 1'b0;
    sel1_s    = 1'b0;
    starved_s = (starve_cnt_r == LIM_C);
    if (rst) begin
      sel0_s = 1'b0;
      sel1_s = 1'b0;
    end else if (req0 && req1) begin
      sel0_s = !starved_s;
      sel1_s = starved_s;
    end else if (req0) begin
      sel0_s = 1'b1;
    end else if (req1) begin
      sel1_s = 1'b1;
    end else begin
      sel0_s = 1'b0;
      sel1_s = 1'b0;
    end
  end

  assign gnt0 = sel0_s;
  assign gnt1 = sel1_s;

  // RAM port 2 is steered by the winner and parked at zero when idle.
  always_comb begin
    ram_addr2  = {ADDR_W{1'b0}};
    ram_in2    = {DATA_W{1'b0}};
    ram_w_en2  = 1'b0;
    rd_issue_s = 1'b0;
    case ({sel1_s, sel0_s})
      2'b01: begin
        ram_addr2  = addr0;
        ram_in2    = wdata0;
        ram_w_en2  = we0;
        rd_issue_s = !we0;
      end
      2'b10: begin
        ram_addr2  = addr1;
        ram_in2    = wdata1;
        ram_w_en2  = we1;
        rd_issue_s = !we1;
      end
      default: begin
        ram_addr2  = {ADDR_W{1'b0}};
        ram_in2    = {DATA_W{1'b0}};
        ram_w_en2  = 1'b0;
        rd_issue_s = 1'b0;
      end
    endcase
  end

  // Consecutive-denial counter for requester 1, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (sel1_s || !req1) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (starve_cnt_r != LIM_C) begin
      starve_cnt_r <= starve_cnt_r + CNT_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // In-flight read tracker: one {valid, owner} slot per cycle of read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_r <= {RD_LAT{1'b0}};
      pipe_own_r <= {RD_LAT{1'b0}};
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_own_r[i] <= pipe_own_r[i-1];
      end
      pipe_vld_r[0] <= rd_issue_s;
      pipe_own_r[0] <= rd_issue_s & sel1_s;
    end
  end

  assign tail_vld_s = pipe_vld_r[RD_LAT-1];
  assign tail_own_s = pipe_own_r[RD_LAT-1];

  // Read data is masked outside its valid cycle so idle outputs stay at zero.
  assign rvalid0 = !rst && tail_vld_s && !tail_own_s;
  assign rvalid1 = !rst && tail_vld_s && tail_own_s;
  assign rdata0  = rvalid0 ? ram_data2 : {DATA_W{1'b0}};
  assign rdata1  = rvalid1 ? ram_data2 : {DATA_W{1'b0}};

endmodule

// Protocol invariants of the arbiter outputs, kept out of the datapath.
module ram2_arbiter_checker (
  input logic clk,
  input logic rst,
  input logic gnt0,
  input logic gnt1,
  input logic rvalid0,
  input logic rvalid1
);

  // Mutual exclusion of grants and of read returns, and silence in reset.
  always_ff @(posedge clk) begin
    assert (!(gnt0 && gnt1)) else $error("FAIL chk_gnt_excl observed=both expected=one");
    assert (!(rvalid0 && rvalid1)) else $error("FAIL chk_rvalid_excl observed=both expected=one");
    if (rst) begin
      assert (!(gnt0 || gnt1)) else $error("FAIL chk_rst_gnt observed=1 expected=0");
    end
  end

endmodule

// File: tb/tb_ram2_arbiter.sv
// Directed bench for ram2_arbiter with a one-cycle synchronous RAM model.
module tb_ram2_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] ram_addr2;
  logic [DATA_W-1:0] ram_in2;
  logic              ram_w_en2;
  logic [DATA_W-1:0] ram_data2;

  logic [DATA_W-1:0] mem [0:2047];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram2_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_addr2(ram_addr2), .ram_in2(ram_in2), .ram_w_en2(ram_w_en2),
    .ram_data2(ram_data2)
  );

  ram2_arbiter_checker u_chk (
    .clk(clk), .rst(rst), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1)
  );

  // RAM model: contents preloaded while in reset, one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      mem[11'h010] <= 32'hDEADBEEF;
      mem[11'h001] <= 32'hA1A1A1A1;
      mem[11'h002] <= 32'hB2B2B2B2;
      mem[11'h003] <= 32'hC3C3C3C3;
    end else if (ram_w_en2) begin
      mem[ram_addr2] <= ram_in2;
    end
    ram_data2 <= mem[ram_addr2];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] pat1;
    logic [4:0] pat5;
    rst = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    tick();
    // requests during reset must not be granted
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; addr0 = 11'h055; wdata0 = 32'h11111111;
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_wen", 32'(ram_w_en2), 32'd0);
    chk("rst_addr", 32'(ram_addr2), 32'd0);
    chk("rst_in", ram_in2, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    tick();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0;

    // single read by requester 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h010;
    #1;
    chk("rd_gnt0", 32'(gnt0), 32'd1);
    chk("rd_gnt1", 32'(gnt1), 32'd0);
    chk("rd_addr", 32'(ram_addr2), 32'h010);
    chk("rd_wen", 32'(ram_w_en2), 32'd0);
    chk("rd_rv_early", 32'(rvalid0), 32'd0);
    tick();
    req0 = 1'b0;
    #1;
    chk("rd_rvalid0", 32'(rvalid0), 32'd1);
    chk("rd_rdata0", rdata0, 32'hDEADBEEF);
    chk("rd_rvalid1", 32'(rvalid1), 32'd0);
    tick();
    chk("rd_rv_once", 32'(rvalid0), 32'd0);

    // write then read back by requester 1
    req1 = 1'b1; we1 = 1'b1; addr1 = 11'h7FF; wdata1 = 32'h12345678;
    #1;
    chk("wr_gnt1", 32'(gnt1), 32'd1);
    chk("wr_wen", 32'(ram_w_en2), 32'd1);
    chk("wr_in", ram_in2, 32'h12345678);
    chk("wr_addr", 32'(ram_addr2), 32'h7FF);
    tick();
    we1 = 1'b0;
    #1;
    chk("wr_no_rv", {30'd0, rvalid1, rvalid0}, 32'd0);
    chk("rb_gnt1", 32'(gnt1), 32'd1);
    tick();
    req1 = 1'b0;
    #1;
    chk("rb_rvalid1", 32'(rvalid1), 32'd1);
    chk("rb_rdata1", rdata1, 32'h12345678);
    chk("rb_rvalid0", 32'(rvalid0), 32'd0);
    tick();

    // sustained contention: four grants to 0, then one to 1, repeating
    pat1 = 10'b1000010000;
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h100; wdata0 = 32'h0000AAAA;
    req1 = 1'b1; we1 = 1'b1; addr1 = 11'h200; wdata1 = 32'h0000BBBB;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("cont_gnt1_c%0d", c + 1), 32'(gnt1), 32'(pat1[c]));
      chk($sformatf("cont_gnt0_c%0d", c + 1), 32'(gnt0), 32'(!pat1[c]));
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // alternating-owner back-to-back reads
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h001;
    #1;
    chk("alt_gnt0_a", 32'(gnt0), 32'd1);
    tick();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 11'h002;
    #1;
    chk("alt_gnt1_b", 32'(gnt1), 32'd1);
    chk("alt_rv0_a", 32'(rvalid0), 32'd1);
    chk("alt_rd0_a", rdata0, 32'hA1A1A1A1);
    tick();
    req1 = 1'b0; req0 = 1'b1; addr0 = 11'h003;
    #1;
    chk("alt_gnt0_c", 32'(gnt0), 32'd1);
    chk("alt_rv1_b", 32'(rvalid1), 32'd1);
    chk("alt_rd1_b", rdata1, 32'hB2B2B2B2);
    chk("alt_rv0_b", 32'(rvalid0), 32'd0);
    tick();
    req0 = 1'b0;
    #1;
    chk("alt_rv0_c", 32'(rvalid0), 32'd1);
    chk("alt_rd0_c", rdata0, 32'hC3C3C3C3);
    chk("alt_rv1_c", 32'(rvalid1), 32'd0);
    tick();

    // reset mid-read after three denials of requester 1
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h010;
    req1 = 1'b1; we1 = 1'b1; addr1 = 11'h200; wdata1 = 32'h0000CCCC;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("pre_rst_gnt0_c%0d", c + 1), 32'(gnt0), 32'd1);
      tick();
    end
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("mid_rst_rv0", 32'(rvalid0), 32'd0);
    chk("mid_rst_rd0", rdata0, 32'd0);
    chk("mid_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("mid_rst_port", {20'd0, ram_w_en2, ram_addr2}, 32'd0);
    chk("mid_rst_in", ram_in2, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_rv", {30'd0, rvalid1, rvalid0}, 32'd0);
    pat5 = 5'b10000;
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h100;
    req1 = 1'b1; we1 = 1'b1; addr1 = 11'h200;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("post_rst_gnt1_c%0d", c + 1), 32'(gnt1), 32'(pat5[c]));
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // early drop of requester 1 restarts the starvation count
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("drop_deny_c%0d", c + 1), 32'(gnt1), 32'd0);
      tick();
    end
    req1 = 1'b0;
    #1;
    chk("drop_gnt0", 32'(gnt0), 32'd1);
    tick();
    req1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("drop_gnt1_c%0d", c + 1), 32'(gnt1), 32'(pat5[c]));
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram2_arbiter.md
Name: ram2_arbiter

Overview:
- Shares the second RAM port (ram_addr2 / ram_in2 / ram_w_en2 / ram_data2) between two requesters.
- Requester 0 is the CPU load/store path (controller/datapath); requester 1 is a secondary master (program loader / debug DMA).
- Fixed priority to requester 0, with a starvation counter that forces a grant to requester 1 after STARVE_LIM denied cycles.
- Tracks in-flight reads so read data is returned only to the requester that issued the read.

Parameters:
ADDR_W, 11, RAM word-address width.
DATA_W, 32, RAM data width.
RD_LAT, 1, cycles from granted read edge to ram_data2 valid (>=1).
STARVE_LIM, 4, consecutive denied cycles of requester 1 before it takes priority (>=1).

Ports:
clk  in  1  single clock; all state on posedge clk.
rst  in  1  synchronous, active-high reset.
req0  in  1  requester 0 (CPU) access request.
we0  in  1  requester 0: 1 = write, 0 = read.
addr0  in  ADDR_W  requester 0 word address.
wdata0  in  DATA_W  requester 0 write data.
gnt0  out  1  requester 0 granted this cycle.
rvalid0  out  1  read data valid for requester 0.
rdata0  out  DATA_W  read data for requester 0.
req1, we1, addr1, wdata1  in  1/1/ADDR_W/DATA_W  requester 1 equivalents.
gnt1, rvalid1, rdata1  out  1/1/DATA_W  requester 1 equivalents.
ram_addr2  out  ADDR_W  RAM port 2 address.
ram_in2  out  DATA_W  RAM port 2 write data.
ram_w_en2  out  1  RAM port 2 write enable.
ram_data2  in  DATA_W  RAM port 2 read data.

Behaviour:
- Handshake: requester raises req with we/addr/wdata stable. gnt is combinational in the same cycle. The access completes at the posedge where req&gnt=1. Requester may drop req before gnt with no side effect.
- Exactly one access per cycle; gnt0 and gnt1 are never both 1.
- Arbitration: if only one req, that requester wins. If both, requester 0 wins unless starve_cnt==STARVE_LIM, in which case requester 1 wins.
- While rst=1, or in the reset cycle itself, no gnt is issued.
- starve_cnt (width clog2(STARVE_LIM+1)):
  - reset 0;
  - cleared when gnt1=1 or req1=0;
  - increments, saturating at STARVE_LIM, when req1=1 and gnt1=0.
- Port drive is combinational from the winner: ram_addr2=addr_w, ram_in2=wdata_w, ram_w_en2=we_w.
- With no winner: ram_addr2=0, ram_in2=0, ram_w_en2=0.
- Read tracking: RD_LAT-deep shift register of {valid, owner}, reset all-zero.
  - On a granted read, insert {1, winner}; otherwise insert {0, x}.
  - At the tail: if valid, rvalid_owner=1 for exactly one cycle and rdata_owner=ram_data2.
  - Non-owner rvalid=0.
- rdata outputs are combinational from ram_data2 and are only meaningful when the matching rvalid=1.
- Writes produce no rvalid.
- Back-to-back reads (including alternating owners) are fully pipelined: one rvalid per granted read, in issue order, RD_LAT cycles later.
- Reset mid-read: the pipeline is cleared; a pending rvalid is never produced.
- Reset values: gnt0=gnt1=rvalid0=rvalid1=0, ram_w_en2=0, ram_addr2=0, ram_in2=0, starve_cnt=0.

Test Plan:
- Single read: req0=1, we0=0, addr0=0x010, RAM[0x010]=0xDEADBEEF. Expected: gnt0=1 that cycle, ram_addr2=0x010, ram_w_en2=0; rvalid0=1 with rdata0=0xDEADBEEF RD_LAT cycles later; rvalid1 stays 0.
- Write then read back: req1 writes 0x12345678 to 0x7FF (no req0). Expected: gnt1=1, ram_w_en2=1, ram_in2=0x12345678, no rvalid. A following read of 0x7FF by requester 1 returns 0x12345678 on rvalid1.
- Contention and starvation, STARVE_LIM=4: req0 and req1 held high continuously. Expected: gnt0 for 4 cycles, gnt1 on cycle 5, then the pattern repeats. gnt0&gnt1 is never 1.
- Alternating reads: grants 0,1,0 to addresses 1,2,3 on consecutive cycles. Expected: rvalid0, rvalid1, rvalid0 on consecutive cycles with the matching data.
- Reset mid-flight: granted read by requester 0, then rst=1 on the next edge. Expected: no rvalid0 after reset; all outputs 0; starve_cnt=0.
- Early drop: req1 asserted for 2 denied cycles, then dropped, then reasserted under contention. Expected: starve_cnt restarts from 0, and requester 1 needs 4 further denied cycles before it is granted.
